alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
// - ID->EX producer for the ALU: decodes one RV32I instruction per handshake into {a, b, alu_op}.
// - Captures rs1/rs2 read data and holds everything in one registered pipeline slot.
// - Sits between fetch/regfile and the combinational ALU; the ALU consumes ex_a/ex_b/ex_alu_op directly.
// PARAMETERS
// - XLEN       32  datapath width; must equal `XLEN
// - OP_W        4  alu_op width; must equal `ALU_OP_WIDTH
// PORTS
// - clk           in   1      sole clock, rising edge
// - rst_n         in   1      synchronous active-low reset
// - flush         in   1      kill slot contents and any same-cycle accept
// - in_valid      in   1      fetch has an instruction
// - in_ready      out  1      stage can accept this cycle
// - in_instr      in   32     instruction word
// - in_pc         in   XLEN   instruction address
// - rs1_data      in   XLEN   regfile read of in_instr[19:15], same cycle
// - rs2_data      in   XLEN   regfile read of in_instr[24:20], same cycle
// - ex_valid      out  1      slot holds a live op
// - ex_ready      in   1      EX consumes slot this cycle
// - ex_a          out  XLEN   ALU operand a
// - ex_b          out  XLEN   ALU operand b
// - ex_alu_op     out  OP_W   one of `ALU_OP_* codes
// - ex_rd         out  5      destination register
// - ex_we         out  1      writeback enable (0 when rd==x0)
// - ex_branch     out  1      conditional branch; ALU output is the taken flag
// - ex_illegal    out  1      undecodable instruction
// BEHAVIOUR
// - Reset (rst_n=0 at edge): every ex_* output is 0; ex_alu_op=`ALU_OP_ADD (assigned value 0 for reset purposes).
// - in_ready = !ex_valid | ex_ready (combinational); accept = in_valid & in_ready & !flush.
// - Latency 1: accepted instruction appears on ex_* at the next edge. Full throughput when ex_ready=1.
// - Slot: accept -> load, ex_valid=1; else ex_ready -> ex_valid=0; else hold all ex_* stable.
// - Simultaneous consume+accept: new op replaces old in the same edge, no bubble.
// - flush: ex_valid=0 at the next edge, payload don't-care; overrides accept and hold.
// - ex_valid=1 with ex_ready=0 and in_valid=1: in_ready=0, inputs are not sampled, and the slot holds.
// - Decode (opcode -> a, b, op, we):
//   OP       a=rs1, b=rs2; f3 -> ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND; f7=0x20 with f3 000->SUB, 101->SRA; any other f7!=0 -> illegal
//   OP-IMM   a=rs1, b=sext(I-imm); shifts: b=shamt, instr[25] must be 0; SRAI if instr[30]=1
//   LUI      a=0,   b=U-imm,  ADD | AUIPC a=pc, b=U-imm, ADD
//   JAL/JALR a=pc,  b=4,      ADD (link value), we=1
//   BRANCH   a=rs1, b=rs2, we=0, ex_branch=1; BEQ->SEQ, BNE->SNE, BLT->SLT, BGE->SGE, BLTU->SLTU, BGEU->SGEU; f3 010/011 -> illegal
//   LOAD     a=rs1, b=sext(I-imm), ADD | STORE a=rs1, b=sext(S-imm), ADD, we=0
//   Anything else (incl. instr[1:0]!=2'b11) -> illegal
// - Illegal: ex_illegal=1, ex_we=0, ex_branch=0, a=b=0, op=ADD; the op is still handed over via handshake.
// - ex_we=0 whenever rd==0. All arithmetic is XLEN-wide; immediates are sign-extended from bit 31.
// CONFIGURATION
// - ALU_ISSUE_FWD_EN defined: extra inputs fwd_valid(1), fwd_rd(5), fwd_data(XLEN).
//   When fwd_valid && fwd_rd!=0 && fwd_rd==rs1 (or rs2), fwd_data replaces rs1_data (or rs2_data) at accept.
//   Forwarding applies to rs1 and rs2 independently.
// - ALU_ISSUE_FWD_EN undefined: these ports are absent and rs*_data is used unmodified.
// TESTING
// - Reset: rst_n=0 for 2 cycles -> ex_valid=0, ex_we=0, ex_illegal=0, in_ready=1.
// - ADDI x5,x1,-3 (0xFFD08293), rs1_data=10 -> next cycle a=10, b=0xFFFFFFFD, op=ADD, rd=5, we=1.
// - SUB x3,x1,x2 (0x402081B3), then SRAI x4,x1,4 (0x4040D213) back-to-back, ex_ready=1 -> op=SUB, then op=SRA with b=4 and no bubble.
// - BGEU x1,x2 (0x0020F063) -> op=SGEU, ex_branch=1, we=0.
//   Then 0xFFFFFFFF -> ex_illegal=1, we=0.
// - Backpressure: ex_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and ex_* stable.
//   Then assert flush -> ex_valid=0 next cycle and no instruction accepted.
// - FWD_EN: fwd_rd=1, fwd_data=0x55, fwd_valid=1, ADD x7,x1,x1 -> a=b=0x55.
//   Repeat with fwd_rd=0 -> a=b=rs1_data.

Source files
------------

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I decode into one registered ALU issue slot (optional forwarding: ALU_ISSUE_FWD_EN)

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD  4'd0
`define ALU_OP_SUB  4'd1
`define ALU_OP_SLL  4'd2
`define ALU_OP_SLT  4'd3
`define ALU_OP_SLTU 4'd4
`define ALU_OP_XOR  4'd5
`define ALU_OP_SRL  4'd6
`define ALU_OP_SRA  4'd7
`define ALU_OP_OR   4'd8
`define ALU_OP_AND  4'd9
`define ALU_OP_SEQ  4'd10
`define ALU_OP_SNE  4'd11
`define ALU_OP_SGE  4'd12
`define ALU_OP_SGEU 4'd13
`endif

module alu_issue_stage #(
   parameter int XLEN = `XLEN,
   parameter int OP_W = `ALU_OP_WIDTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
`ifdef ALU_ISSUE_FWD_EN
   input  logic            fwd_valid,
   input  logic [4:0]      fwd_rd,
   input  logic [XLEN-1:0] fwd_data,
`endif
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_a,
   output logic [XLEN-1:0] ex_b,
   output logic [OP_W-1:0] ex_alu_op,
   output logic [4:0]      ex_rd,
   output logic            ex_we,
   output logic            ex_branch,
   output logic            ex_illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [OP_W-1:0] OP_ADD  = `ALU_OP_ADD;
   localparam logic [OP_W-1:0] OP_SUB  = `ALU_OP_SUB;
   localparam logic [OP_W-1:0] OP_SLL  = `ALU_OP_SLL;
   localparam logic [OP_W-1:0] OP_SLT  = `ALU_OP_SLT;
   localparam logic [OP_W-1:0] OP_SLTU = `ALU_OP_SLTU;
   localparam logic [OP_W-1:0] OP_XOR  = `ALU_OP_XOR;
   localparam logic [OP_W-1:0] OP_SRL  = `ALU_OP_SRL;
   localparam logic [OP_W-1:0] OP_SRA  = `ALU_OP_SRA;
   localparam logic [OP_W-1:0] OP_OR   = `ALU_OP_OR;
   localparam logic [OP_W-1:0] OP_AND  = `ALU_OP_AND;
   localparam logic [OP_W-1:0] OP_SEQ  = `ALU_OP_SEQ;
   localparam logic [OP_W-1:0] OP_SNE  = `ALU_OP_SNE;
   localparam logic [OP_W-1:0] OP_SGE  = `ALU_OP_SGE;
   localparam logic [OP_W-1:0] OP_SGEU = `ALU_OP_SGEU;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      rd;
   logic [31:0]     imm_i32;
   logic [31:0]     imm_s32;
   logic [31:0]     imm_u32;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic            accept;

   logic [XLEN-1:0] dec_a;
   logic [XLEN-1:0] dec_b;
   logic [OP_W-1:0] dec_op;
   logic            dec_we;
   logic            dec_br;
   logic            dec_ill;

   assign opcode  = in_instr[6:0];
   assign funct3  = in_instr[14:12];
   assign funct7  = in_instr[31:25];
   assign rd      = in_instr[11:7];
   assign imm_i32 = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_u32 = {in_instr[31:12], 12'b0};
   assign imm_i   = XLEN'($signed(imm_i32));
   assign imm_s   = XLEN'($signed(imm_s32));
   assign imm_u   = XLEN'($signed(imm_u32));

   assign in_ready = !ex_valid || ex_ready;
   assign accept   = in_valid && in_ready && !flush;

`ifdef ALU_ISSUE_FWD_EN
   // A result still in flight to the regfile wins over the stale read.
   assign src1 = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_instr[19:15]) ? fwd_data : rs1_data;
   assign src2 = (fwd_valid && fwd_rd != 5'd0 && fwd_rd == in_instr[24:20]) ? fwd_data : rs2_data;
`else
   assign src1 = rs1_data;
   assign src2 = rs2_data;
`endif

   function automatic logic [OP_W-1:0] f3_op(input logic [2:0] f3);
      case (f3)
         3'b000:  f3_op = OP_ADD;
         3'b001:  f3_op = OP_SLL;
         3'b010:  f3_op = OP_SLT;
         3'b011:  f3_op = OP_SLTU;
         3'b100:  f3_op = OP_XOR;
         3'b101:  f3_op = OP_SRL;
         3'b110:  f3_op = OP_OR;
         default: f3_op = OP_AND;
      endcase
   endfunction

   always_comb begin
      dec_a   = '0;
      dec_b   = '0;
      dec_op  = OP_ADD;
      dec_we  = 1'b0;
      dec_br  = 1'b0;
      dec_ill = 1'b0;
      case (opcode)
         OPC_OP: begin
            dec_a  = src1;
            dec_b  = src2;
            dec_we = 1'b1;
            if (funct7 == 7'h00)
               dec_op = f3_op(funct3);
            else if (funct7 == 7'h20 && funct3 == 3'b000)
               dec_op = OP_SUB;
            else if (funct7 == 7'h20 && funct3 == 3'b101)
               dec_op = OP_SRA;
            else
               dec_ill = 1'b1;
         end
         OPC_OP_IMM: begin
            dec_a  = src1;
            dec_we = 1'b1;
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec_b   = XLEN'(in_instr[24:20]);
               dec_ill = in_instr[25];
               if (funct3 == 3'b001)
                  dec_op = OP_SLL;
               else
                  dec_op = in_instr[30] ? OP_SRA : OP_SRL;
            end else begin
               dec_b  = imm_i;
               dec_op = f3_op(funct3);
            end
         end
         OPC_LUI: begin
            dec_b  = imm_u;
            dec_we = 1'b1;
         end
         OPC_AUIPC: begin
            dec_a  = in_pc;
            dec_b  = imm_u;
            dec_we = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            dec_a  = in_pc;
            dec_b  = XLEN'(4);
            dec_we = 1'b1;
         end
         OPC_BRANCH: begin
            dec_a  = src1;
            dec_b  = src2;
            dec_br = 1'b1;
            case (funct3)
               3'b000:  dec_op = OP_SEQ;
               3'b001:  dec_op = OP_SNE;
               3'b100:  dec_op = OP_SLT;
               3'b101:  dec_op = OP_SGE;
               3'b110:  dec_op = OP_SLTU;
               3'b111:  dec_op = OP_SGEU;
               default: dec_ill = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec_a  = src1;
            dec_b  = imm_i;
            dec_we = 1'b1;
         end
         OPC_STORE: begin
            dec_a = src1;
            dec_b = imm_s;
         end
         default: dec_ill = 1'b1;
      endcase
      // Illegal ops still travel down the pipe, but as an inert ADD 0,0.
      if (dec_ill) begin
         dec_a  = '0;
         dec_b  = '0;
         dec_op = OP_ADD;
         dec_we = 1'b0;
         dec_br = 1'b0;
      end
      if (rd == 5'd0)
         dec_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         ex_a       <= '0;
         ex_b       <= '0;
         ex_alu_op  <= OP_ADD;
         ex_rd      <= '0;
         ex_we      <= 1'b0;
         ex_branch  <= 1'b0;
         ex_illegal <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (accept) begin
         ex_valid   <= 1'b1;
         ex_a       <= dec_a;
         ex_b       <= dec_b;
         ex_alu_op  <= dec_op;
         ex_rd      <= rd;
         ex_we      <= dec_we;
         ex_branch  <= dec_br;
         ex_illegal <= dec_ill;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - randomized model-checked bench for alu_issue_stage

module tb_alu_issue_stage;

   localparam logic [3:0] L_ADD = 4'd0,  L_SUB = 4'd1,  L_SLL = 4'd2,  L_SLT = 4'd3;
   localparam logic [3:0] L_SLTU = 4'd4, L_XOR = 4'd5,  L_SRL = 4'd6,  L_SRA = 4'd7;
   localparam logic [3:0] L_OR = 4'd8,   L_AND = 4'd9,  L_SEQ = 4'd10, L_SNE = 4'd11;
   localparam logic [3:0] L_SGE = 4'd12, L_SGEU = 4'd13;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        we;
      logic        br;
      logic        ill;
   } dec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_instr = '0;
   logic [31:0] in_pc = '0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        fwd_valid = 1'b0;
   logic [4:0]  fwd_rd = '0;
   logic [31:0] fwd_data = '0;
   logic        ex_valid;
   logic        ex_ready = 1'b0;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [3:0]  ex_alu_op;
   logic [4:0]  ex_rd;
   logic        ex_we;
   logic        ex_branch;
   logic        ex_illegal;

   int   n_checks = 0;
   int   n_fail = 0;
   bit   chk_en = 1'b0;
   bit   mv = 1'b0;
   dec_t m = '0;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef ALU_ISSUE_FWD_EN
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b),
      .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_we(ex_we),
      .ex_branch(ex_branch), .ex_illegal(ex_illegal)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode straight from the ISA field definitions.
   function automatic dec_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] r1, input logic [31:0] r2);
      dec_t d;
      logic [3:0] alu_tab [8];
      logic [3:0] br_tab [8];
      logic [31:0] ii, si, ui;
      alu_tab = '{L_ADD, L_SLL, L_SLT, L_SLTU, L_XOR, L_SRL, L_OR, L_AND};
      br_tab  = '{L_SEQ, L_SNE, L_ADD, L_ADD, L_SLT, L_SGE, L_SLTU, L_SGEU};
      ii = 32'($signed(ins[31:20]));
      si = 32'($signed({ins[31:25], ins[11:7]}));
      ui = {ins[31:12], 12'h000};
      d = '0;
      d.rd = ins[11:7];
      case (ins[6:0])
         7'h33: begin
            d.a = r1; d.b = r2; d.we = 1;
            if (ins[31:25] == 0) d.op = alu_tab[ins[14:12]];
            else if (ins[31:25] == 7'h20 && ins[14:12] == 0) d.op = L_SUB;
            else if (ins[31:25] == 7'h20 && ins[14:12] == 5) d.op = L_SRA;
            else d.ill = 1;
         end
         7'h13: begin
            d.a = r1; d.we = 1;
            if (ins[13:12] == 2'b01) begin
               d.b = {27'd0, ins[24:20]};
               d.ill = ins[25];
               d.op = (ins[14] == 0) ? L_SLL : (ins[30] ? L_SRA : L_SRL);
            end else begin
               d.b = ii; d.op = alu_tab[ins[14:12]];
            end
         end
         7'h37: begin d.b = ui; d.we = 1; end
         7'h17: begin d.a = pc; d.b = ui; d.we = 1; end
         7'h6f, 7'h67: begin d.a = pc; d.b = 4; d.we = 1; end
         7'h63: begin
            d.a = r1; d.b = r2; d.br = 1;
            d.op = br_tab[ins[14:12]];
            if (ins[14:12] == 2 || ins[14:12] == 3) d.ill = 1;
         end
         7'h03: begin d.a = r1; d.b = ii; d.we = 1; end
         7'h23: begin d.a = r1; d.b = si; end
         default: d.ill = 1;
      endcase
      if (d.ill) begin d.a = 0; d.b = 0; d.op = L_ADD; d.we = 0; d.br = 0; end
      if (d.rd == 0) d.we = 0;
      return d;
   endfunction

   always @(posedge clk) begin
      logic [31:0] r1, r2;
      r1 = rs1_data;
      r2 = rs2_data;
`ifdef ALU_ISSUE_FWD_EN
      if (fwd_valid && fwd_rd != 0 && fwd_rd == in_instr[19:15]) r1 = fwd_data;
      if (fwd_valid && fwd_rd != 0 && fwd_rd == in_instr[24:20]) r2 = fwd_data;
`endif
      if (!rst_n) begin
         mv <= 1'b0;
         m  <= '0;
      end else if (flush) begin
         mv <= 1'b0;
      end else if (in_valid && (!mv || ex_ready)) begin
         mv <= 1'b1;
         m  <= model_decode(in_instr, in_pc, r1, r2);
      end else if (ex_ready) begin
         mv <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("ex_valid", 32'(ex_valid), 32'(mv));
         check("in_ready", 32'(in_ready), 32'(!mv || ex_ready));
         if (mv) begin
            check("ex_a", ex_a, m.a);
            check("ex_b", ex_b, m.b);
            check("ex_alu_op", 32'(ex_alu_op), 32'(m.op));
            check("ex_rd", 32'(ex_rd), 32'(m.rd));
            check("ex_we", 32'(ex_we), 32'(m.we));
            check("ex_branch", 32'(ex_branch), 32'(m.br));
            check("ex_illegal", 32'(ex_illegal), 32'(m.ill));
         end
      end
   end

   task automatic drive(input logic rst, input logic v, input logic fl, input logic rdy,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
      rst_n = rst; in_valid = v; flush = fl; ex_ready = rdy;
      in_instr = ins; in_pc = pc; rs1_data = r1; rs2_data = r2;
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      logic [6:0]  opc_tab [10];
      int k;
      opc_tab = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h00};
      ins = $urandom;
      k = $urandom_range(0, 10);
      if (k < 10) ins[6:0] = opc_tab[k];
      if (k == 9) ins[6:0] = 7'($urandom);
      if (ins[6:0] == 7'h33) begin
         case ($urandom_range(0, 3))
            0, 1: ins[31:25] = 7'h00;
            2:    ins[31:25] = 7'h20;
            default: ;
         endcase
      end
      if (ins[6:0] == 7'h13 && $urandom_range(0, 3) != 0) ins[25] = 1'b0;
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      return ins;
   endfunction

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk_en = 1'b1;
      check("rst ex_valid", 32'(ex_valid), 0);
      check("rst ex_we", 32'(ex_we), 0);
      check("rst ex_illegal", 32'(ex_illegal), 0);
      check("rst in_ready", 32'(in_ready), 1);
      check("rst ex_alu_op", 32'(ex_alu_op), 0);
      check("rst ex_a", ex_a, 0);

      drive(1, 1, 0, 1, 32'hFFD08293, 32'h100, 32'd10, 32'd0);
      check("addi valid", 32'(ex_valid), 1);
      check("addi a", ex_a, 32'd10);
      check("addi b", ex_b, 32'hFFFFFFFD);
      check("addi op", 32'(ex_alu_op), 32'(L_ADD));
      check("addi rd", 32'(ex_rd), 5);
      check("addi we", 32'(ex_we), 1);

      drive(1, 1, 0, 1, 32'h402081B3, 32'h104, 32'd7, 32'd3);
      check("sub op", 32'(ex_alu_op), 32'(L_SUB));
      drive(1, 1, 0, 1, 32'h4040D213, 32'h108, 32'd7, 32'd3);
      check("srai valid", 32'(ex_valid), 1);
      check("srai op", 32'(ex_alu_op), 32'(L_SRA));
      check("srai b", ex_b, 32'd4);

      drive(1, 1, 0, 1, 32'h0020F063, 32'h10C, 32'd1, 32'd2);
      check("bgeu op", 32'(ex_alu_op), 32'(L_SGEU));
      check("bgeu branch", 32'(ex_branch), 1);
      check("bgeu we", 32'(ex_we), 0);
      drive(1, 1, 0, 1, 32'hFFFFFFFF, 32'h110, 32'd1, 32'd2);
      check("illegal flag", 32'(ex_illegal), 1);
      check("illegal we", 32'(ex_we), 0);

      drive(1, 1, 0, 1, 32'h001083B3, 32'h114, 32'h11, 32'h22);
      check("bp load a", ex_a, 32'h11);
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 0, 32'h00100093, 32'h118, 32'h99, 32'h99);
         check("bp in_ready", 32'(in_ready), 0);
         check("bp hold a", ex_a, 32'h11);
         check("bp hold b", ex_b, 32'h22);
         check("bp hold valid", 32'(ex_valid), 1);
      end
      drive(1, 1, 1, 0, 32'h00100093, 32'h118, 32'h99, 32'h99);
      check("flush valid", 32'(ex_valid), 0);
      drive(1, 0, 0, 0, 32'h00100093, 32'h11C, 32'h99, 32'h99);
      check("post flush valid", 32'(ex_valid), 0);

`ifdef ALU_ISSUE_FWD_EN
      fwd_valid = 1; fwd_rd = 5'd1; fwd_data = 32'h55;
      drive(1, 1, 0, 1, 32'h001083B3, 32'h120, 32'h33, 32'h33);
      check("fwd a", ex_a, 32'h55);
      check("fwd b", ex_b, 32'h55);
      fwd_rd = 5'd0;
      drive(1, 1, 0, 1, 32'h001083B3, 32'h124, 32'h33, 32'h33);
      check("fwd x0 a", ex_a, 32'h33);
      check("fwd x0 b", ex_b, 32'h33);
      fwd_valid = 0;
`endif

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] ins;
         ins = rand_instr();
`ifdef ALU_ISSUE_FWD_EN
         fwd_valid = 1'($urandom);
         fwd_data  = $urandom;
         case ($urandom_range(0, 3))
            0: fwd_rd = ins[19:15];
            1: fwd_rd = ins[24:20];
            2: fwd_rd = 5'd0;
            default: fwd_rd = 5'($urandom);
         endcase
`endif
         drive($urandom_range(0, 299) != 0, $urandom_range(0, 9) < 8,
               $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
               ins, $urandom, $urandom, $urandom);
      end
      drive(1, 0, 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
